// File: rtl/softmax_lut_sched.sv
// Row-level round-robin scheduler sharing one 8-lane exponent LUT between two requesters.
// Registers the LUT result into a valid/ready stream and accumulates the per-row lane sum.
module softmax_lut_sched #(
    parameter int unsigned ROW_WORDS = 8,
    parameter int unsigned SUM_W     = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [63:0]      req0_data,
    input  logic             req0_last,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [63:0]      req1_data,
    input  logic             req1_last,
    output logic             req1_ready,
    output logic [63:0]      lut_in,
    input  logic [63:0]      lut_out,
    output logic             out_valid,
    output logic [63:0]      out_data,
    output logic             out_src,
    output logic             out_last,
    output logic [SUM_W-1:0] out_sum,
    input  logic             out_ready,
    output logic             row_err
);

    localparam int unsigned LANES   = 8;
    localparam int unsigned LANE_W  = 8;
    localparam int unsigned CNT_W   = (ROW_WORDS > 1) ? $clog2(ROW_WORDS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ROW_WORDS - 1);

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_e;

    typedef struct packed {
        logic             src;
        logic             last;
        logic [SUM_W-1:0] sum;
        logic [63:0]      data;
    } out_beat_t;

    state_e           state_q, state_d;
    logic             grant_q, grant_d;
    logic             prio_q, prio_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SUM_W-1:0] acc_q, acc_d;
    logic             out_valid_q, out_valid_d;
    out_beat_t        out_q, out_d;
    logic             row_err_q, row_err_d;

    logic             sel_valid;
    logic             sel_last;
    logic [63:0]      sel_data;
    logic             busy;
    logic             take;
    logic             accept;
    logic             row_end;
    logic [SUM_W-1:0] lanesum;

    // Granted requester mux; the other requester is never ready.
    assign sel_valid  = grant_q ? req1_valid : req0_valid;
    assign sel_last   = grant_q ? req1_last  : req0_last;
    assign sel_data   = grant_q ? req1_data  : req0_data;
    assign busy       = (state_q == S_BUSY);
    assign take       = busy & (~out_valid_q | out_ready);
    assign accept     = take & sel_valid;
    assign row_end    = sel_last | (cnt_q == CNT_MAX);
    assign req0_ready = take & ~grant_q;
    assign req1_ready = take & grant_q;
    assign lut_in     = busy ? sel_data : 64'd0;

    always_comb begin
        lanesum = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            lanesum = lanesum + SUM_W'(lut_out[LANE_W*i +: LANE_W]);
        end
    end

    // Next-state: arbitration, row bookkeeping and the output register set.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        prio_d      = prio_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_d       = out_q;
        row_err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req0_valid | req1_valid) begin
                    grant_d = (req0_valid & req1_valid) ? prio_q : req1_valid;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (accept) begin
                    if (row_end) begin
                        acc_d     = '0;
                        cnt_d     = '0;
                        prio_d    = ~grant_q;
                        state_d   = S_IDLE;
                        row_err_d = (cnt_q == CNT_MAX) & ~sel_last;
                    end else begin
                        acc_d = acc_q + lanesum;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            out_valid_d = 1'b1;
            out_d.data  = lut_out;
            out_d.src   = grant_q;
            out_d.last  = row_end;
            out_d.sum   = acc_q + lanesum;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            grant_q     <= 1'b0;
            prio_q      <= 1'b0;
            cnt_q       <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            row_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            prio_q      <= prio_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            row_err_q   <= row_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_q.data;
    assign out_src   = out_q.src;
    assign out_last  = out_q.last;
    assign out_sum   = out_q.sum;
    assign row_err   = row_err_q;

endmodule
